// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - MDU_* operation encodings carried on MDUOp
//   - default latencies for multiply and divide
//   - small two's-complement helper used by the signed divider
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // Two's-complement negate when cond is set, pass-through otherwise.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic cond);
    return cond ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu.sv
// mdu: multiply/divide unit sitting beside the ALU in EX.
// The result is computed combinationally at issue and parked in shadow
// registers; a down-counter models the latency and commits the shadows
// into HI/LO on its last cycle.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   A, B            forwarded rs/rt operands
//   MDUOp, start    operation code and valid strobe from EX
//   C               mfhi/mflo read data (combinational)
//   busy            multi-cycle op in flight (registered)
//   stall_req       stall request to the hazard unit
//   HI, LO          architectural HI/LO for trace
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  output logic [31:0] C,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_sh_q, hi_sh_d, lo_sh_q, lo_sh_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;

  logic [63:0] prod_s_s, prod_u_s;
  logic        div_zero_s, is_md_s;
  logic [31:0] divisor_u_s, a_mag_s, b_mag_s;
  logic [31:0] quo_u_s, rem_u_s, mag_q_s, mag_r_s, quo_s_s, rem_s_s;

  // Full-width products; operands are extended to 64 bits so the low 64 bits are exact.
  assign prod_s_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u_s = {32'd0, A} * {32'd0, B};

  // Dividers; a zero divisor is replaced by 1 only to keep the arithmetic defined,
  // the result is never committed in that case.
  always_comb begin
    div_zero_s  = (B == 32'd0);
    divisor_u_s = div_zero_s ? 32'd1 : B;
    quo_u_s     = A / divisor_u_s;
    rem_u_s     = A % divisor_u_s;
    // Signed divide on magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 r 0.
    a_mag_s     = neg_if(A, A[31]);
    b_mag_s     = div_zero_s ? 32'd1 : neg_if(B, B[31]);
    mag_q_s     = a_mag_s / b_mag_s;
    mag_r_s     = a_mag_s % b_mag_s;
    quo_s_s     = neg_if(mag_q_s, A[31] ^ B[31]);
    rem_s_s     = neg_if(mag_r_s, A[31]);
  end

  // Decode of ops that occupy the unit for several cycles.
  always_comb begin
    case (MDUOp)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: is_md_s = 1'b1;
      default:                                is_md_s = 1'b0;
    endcase
  end

  // Next-state: count down and commit while running, otherwise accept a new op.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_sh_d = hi_sh_q;
    lo_sh_d = lo_sh_q;
    count_d = count_q;
    if (busy_q) begin
      // Any start during a run is dropped; the hazard unit holds it upstream.
      if (count_q == CNT_W'(1)) begin
        hi_d    = hi_sh_q;
        lo_d    = lo_sh_q;
        count_d = '0;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end else if (start) begin
      case (MDUOp)
        MDU_MULT: begin
          {hi_sh_d, lo_sh_d} = prod_s_s;
          count_d            = CNT_W'(MULT_CYCLES);
        end
        MDU_MULTU: begin
          {hi_sh_d, lo_sh_d} = prod_u_s;
          count_d            = CNT_W'(MULT_CYCLES);
        end
        MDU_DIV: begin
          // Divide by zero still runs the full latency but commits the current HI/LO.
          hi_sh_d = div_zero_s ? hi_q : rem_s_s;
          lo_sh_d = div_zero_s ? lo_q : quo_s_s;
          count_d = CNT_W'(DIV_CYCLES);
        end
        MDU_DIVU: begin
          hi_sh_d = div_zero_s ? hi_q : rem_u_s;
          lo_sh_d = div_zero_s ? lo_q : quo_u_s;
          count_d = CNT_W'(DIV_CYCLES);
        end
        MDU_MTHI: hi_d = A;
        MDU_MTLO: lo_d = A;
        default: begin
          hi_d = hi_q;
        end
      endcase
    end else begin
      count_d = count_q;
    end
    busy_d = (count_d != '0);
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_sh_q <= 32'd0;
      lo_sh_q <= 32'd0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_sh_q <= hi_sh_d;
      lo_sh_q <= lo_sh_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  // mfhi/mflo read port, independent of start and busy.
  always_comb begin
    case (MDUOp)
      MDU_MFHI: C = hi_q;
      MDU_MFLO: C = lo_q;
      default:  C = 32'd0;
    endcase
  end

  assign busy      = busy_q;
  assign stall_req = busy_q | (start & is_md_s);
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [3:0]  MDUOp = 4'd0;
  logic        start = 1'b0;
  logic [31:0] C, HI, LO;
  logic        busy, stall_req;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          n;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          n;
  } exp_t;

  vec_t tbl[10];
  exp_t sb[$];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .MDUOp(MDUOp), .start(start),
    .C(C), .busy(busy), .stall_req(stall_req), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one op for one cycle (inputs set on the falling edge), check the
  // issue-cycle stall, and leave the bench at the falling edge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_stall);
    @(negedge clk);
    MDUOp = op; A = a; B = b; start = 1'b1;
    #1 chk("issue_stall", {63'd0, stall_req}, {63'd0, exp_stall});
    @(negedge clk);
    MDUOp = MDU_NONE; start = 1'b0; A = 32'd0; B = 32'd0;
  endtask

  // Count busy cycles from the current falling edge until busy drops (bounded).
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      n_vec++; n_err++;
      $display("FAIL busy_timeout: got busy stuck expected release");
    end
  endtask

  task automatic check_read(input logic [31:0] ehi, input logic [31:0] elo);
    MDUOp = MDU_MFHI;
    #1 chk("C_mfhi", {32'd0, C}, {32'd0, ehi});
    MDUOp = MDU_MFLO;
    #1 chk("C_mflo", {32'd0, C}, {32'd0, elo});
    MDUOp = MDU_NONE;
  endtask

  initial begin
    int   n;
    logic stall_ok;
    exp_t e;

    tbl[0] = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    tbl[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    tbl[2] = '{MDU_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    tbl[3] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    tbl[5] = '{MDU_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    tbl[6] = '{MDU_DIV,   32'd5,        32'd0,        32'h3FFFFFFF, 32'h00000001, 10};
    tbl[7] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    tbl[8] = '{MDU_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    tbl[9] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 10};

    // Reset state.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    chk("rst_stall", {63'd0, stall_req}, 64'd0);
    check_read(32'd0, 32'd0);

    // Table: issue, push expectation, wait for completion, pop and compare.
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1);
      sb.push_back('{tbl[i].hi, tbl[i].lo, tbl[i].n});
      wait_idle(n);
      chk("post_stall", {63'd0, stall_req}, 64'd0);
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
        e = sb.pop_front();
        chk("busy_len", 64'(n), 64'(e.n));
        chk("HI", {32'd0, HI}, {32'd0, e.hi});
        chk("LO", {32'd0, LO}, {32'd0, e.lo});
        check_read(e.hi, e.lo);
      end
    end

    // Busy ignore: MTLO and DIV offered mid-run are dropped; stall held throughout.
    issue(MDU_DIV, 32'd100, 32'd7, 1'b1);
    n = 0;
    stall_ok = 1'b1;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == 2) begin
        MDUOp = MDU_MTLO; A = 32'h1234; start = 1'b1;
      end else if (n == 3) begin
        MDUOp = MDU_DIV; A = 32'd1; B = 32'd1; start = 1'b1;
      end else begin
        MDUOp = MDU_NONE; start = 1'b0;
      end
      #1 if (stall_req !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
    end
    MDUOp = MDU_NONE; start = 1'b0; A = 32'd0; B = 32'd0;
    chk("ign_stall", {63'd0, stall_ok}, 64'd1);
    chk("ign_len", 64'(n), 64'd10);
    chk("ign_hilo", {HI, LO}, {32'd2, 32'd14});
    @(negedge clk);
    chk("ign_no_rerun", {63'd0, busy}, 64'd0);

    // Reset in run cycle 3 of a MULT.
    issue(MDU_MULT, 32'd3, 32'd4, 1'b1);
    repeat (2) @(negedge clk);
    chk("mid_busy_pre", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {63'd0, busy}, 64'd0);
    chk("mid_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    chk("mid_discard", {HI, LO}, 64'd0);

    // mthi then mfhi back to back, no bubble; same for mtlo/mflo.
    MDUOp = MDU_MTHI; A = 32'hABCD; start = 1'b1;
    #1 chk("mt_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    MDUOp = MDU_MFHI; A = 32'd0;
    #1 chk("mfhi_next", {32'd0, C}, 64'h0000_0000_0000_ABCD);
    chk("mt_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    MDUOp = MDU_MTLO; A = 32'h5A5A0F0F;
    @(negedge clk);
    MDUOp = MDU_MFLO; A = 32'd0;
    #1 chk("mflo_next", {32'd0, C}, 64'h0000_0000_5A5A_0F0F);
    chk("mt_hi_kept", {32'd0, HI}, 64'h0000_0000_0000_ABCD);
    @(negedge clk);
    MDUOp = MDU_NONE; start = 1'b0;
    #1 chk("C_none", {32'd0, C}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
